// File: rtl/smsdac_sample_scheduler_if.sv
// Sample ingress handshake and modulator egress bundle
// for the SMS DAC sample scheduler.
interface smsdac_sample_scheduler_if #(
  parameter int DW = 8
);
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] mod_data;
  logic          mod_strobe;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mod_data,
    input  mod_strobe
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mod_data,
    output mod_strobe
  );
endinterface

// File: rtl/smsdac_sample_scheduler.sv
// Sample FIFO with priming, paced release and underflow repeat
// feeding the SMS modulator core.
module smsdac_sample_scheduler #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int DIVW  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   run,
  input  logic [DIVW-1:0]        rate,
  input  logic                   clr,
  smsdac_sample_scheduler_if.slave bus,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] fill,
  output logic [1:0]             state
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;
  localparam logic [FW-1:0] FULL = FW'(DEPTH);
  localparam logic [FW-1:0] HALF = FW'(DEPTH / 2);
  localparam logic [DW-1:0] MID  = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } st_e;

  st_e           state_q, state_d;
  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [DW-1:0] data_q, data_d;
  logic          strobe_q, strobe_d;
  logic          uf_q, uf_d;
  logic [DW-1:0] mem_q [DEPTH];

  logic push;
  logic pop;

  assign bus.in_ready   = rst_n && ena && (fill_q < FULL);
  assign bus.mod_data   = data_q;
  assign bus.mod_strobe = strobe_q && ena;
  assign underflow      = uf_q;
  assign fill           = fill_q;
  assign state          = state_q;
  assign push           = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    strobe_d = 1'b0;
    uf_d     = uf_q && !clr;
    pop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        data_d = MID;
        cnt_d  = '0;
        if (run) state_d = S_PRIME;
      end
      S_PRIME: begin
        cnt_d = '0;
        if (!run) state_d = S_IDLE;
        else if (fill_q >= HALF) state_d = S_RUN;
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
          data_d  = MID;
          cnt_d   = '0;
        end else if (cnt_q >= rate) begin
          // >= so a lowered rate fires at once
          cnt_d    = '0;
          strobe_d = 1'b1;
          if (fill_q != '0) begin
            pop    = 1'b1;
            data_d = mem_q[rd_q];
          end else begin
            uf_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIVW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    wr_d   = push ? wr_q + PW'(1) : wr_q;
    rd_d   = pop ? rd_q + PW'(1) : rd_q;
    fill_d = fill_q + FW'(push) - FW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      fill_q   <= '0;
      data_q   <= MID;
      strobe_q <= 1'b0;
      uf_q     <= 1'b0;
    end else if (ena) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      fill_q   <= fill_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      uf_q     <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.in_data;
  end

endmodule

// File: tb/tb_smsdac_sample_scheduler.sv
// Directed bench for smsdac_sample_scheduler with a sample
// scoreboard checked on every modulator strobe.
module tb_smsdac_sample_scheduler;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int DIVW  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic            run;
  logic [DIVW-1:0] rate;
  logic            clr;
  logic            underflow;
  logic [2:0]      fill;
  logic [1:0]      state;

  smsdac_sample_scheduler_if #(.DW(DW)) bus ();

  smsdac_sample_scheduler #(
    .DW(DW),
    .DEPTH(DEPTH),
    .DIVW(DIVW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .run(run),
    .rate(rate),
    .clr(clr),
    .bus(bus.slave),
    .underflow(underflow),
    .fill(fill),
    .state(state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic [7:0] sb [$];
  logic [7:0] last = 8'h80;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] d);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    chk("in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    sb.push_back(d);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input int gap,
                             input logic exp_uf);
    int k;
    logic [7:0] e;
    k = 0;
    do begin
      cyc();
      k++;
    end while (bus.mod_strobe !== 1'b1 && k < 64);
    chk({tag, ".gap"}, 32'(k), 32'(gap));
    if (sb.size() > 0) e = sb.pop_front();
    else e = last;
    last = e;
    chk({tag, ".data"}, 32'(bus.mod_data), 32'(e));
    chk({tag, ".uf"}, 32'(underflow), 32'(exp_uf));
  endtask

  initial begin
    int seen;
    int rdy;
    rst_n        = 1'b0;
    ena          = 1'b1;
    run          = 1'b0;
    rate         = 8'd3;
    clr          = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    cyc();
    cyc();
    chk("rst.in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst.mod_data", 32'(bus.mod_data), 32'h80);
    chk("rst.strobe", 32'(bus.mod_strobe), 32'd0);
    chk("rst.fill", 32'(fill), 32'd0);
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.uf", 32'(underflow), 32'd0);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    cyc();

    push_word(8'h10);
    push_word(8'h20);
    push_word(8'h30);
    push_word(8'h40);
    chk("prime.fill", 32'(fill), 32'd4);
    run = 1'b1;
    cyc();
    chk("prime.state", 32'(state), 32'd1);
    cyc();
    chk("run.state", 32'(state), 32'd2);
    wait_strobe("s1", 4, 1'b0);
    wait_strobe("s2", 4, 1'b0);
    wait_strobe("s3", 4, 1'b0);
    wait_strobe("s4", 4, 1'b0);
    chk("drain.fill", 32'(fill), 32'd0);

    wait_strobe("s5", 4, 1'b1);
    cyc();
    cyc();
    cyc();
    clr = 1'b1;
    wait_strobe("s6clr", 1, 1'b1);
    cyc();
    chk("clr.uf", 32'(underflow), 32'd0);
    clr = 1'b0;

    run = 1'b0;
    cyc();
    chk("idle.state", 32'(state), 32'd0);
    chk("idle.mod_data", 32'(bus.mod_data), 32'h80);
    rate = 8'd0;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    push_word(8'h44);
    chk("full.in_ready", 32'(bus.in_ready), 32'd0);
    chk("full.fill", 32'(fill), 32'd4);
    bus.in_data  = 8'h99;
    bus.in_valid = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("ovf.fill", 32'(fill), 32'd4);
    run = 1'b1;
    cyc();
    cyc();
    wait_strobe("bp", 1, 1'b0);
    chk("bp.in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp.fill", 32'(fill), 32'd3);
    run = 1'b0;
    cyc();
    chk("stop1.state", 32'(state), 32'd0);
    chk("stop1.strobe", 32'(bus.mod_strobe), 32'd0);
    chk("stop1.fill", 32'(fill), 32'd3);

    rate = 8'd200;
    run  = 1'b1;
    cyc();
    cyc();
    chk("rate.state", 32'(state), 32'd2);
    seen = 0;
    repeat (50) begin
      cyc();
      if (bus.mod_strobe === 1'b1) seen++;
    end
    chk("rate.quiet", 32'(seen), 32'd0);
    rate = 8'd10;
    wait_strobe("rate", 1, 1'b0);
    cyc();
    cyc();
    cyc();
    ena  = 1'b0;
    seen = 0;
    rdy  = 0;
    repeat (5) begin
      cyc();
      if (bus.mod_strobe !== 1'b0) seen++;
      if (bus.in_ready !== 1'b0) rdy++;
    end
    chk("frz.strobe", 32'(seen), 32'd0);
    chk("frz.in_ready", 32'(rdy), 32'd0);
    chk("frz.fill", 32'(fill), 32'd2);
    chk("frz.mod_data", 32'(bus.mod_data), 32'h22);
    ena = 1'b1;
    wait_strobe("thaw", 8, 1'b0);

    cyc();
    cyc();
    run = 1'b0;
    cyc();
    chk("stop.state", 32'(state), 32'd0);
    chk("stop.mod_data", 32'(bus.mod_data), 32'h80);
    chk("stop.strobe", 32'(bus.mod_strobe), 32'd0);
    chk("stop.fill", 32'(fill), 32'(sb.size()));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smsdac_sample_scheduler.md
# smsdac_sample_scheduler

Sample scheduler for the segmented mismatch-shaping DAC. It accepts 8-bit samples over a valid/ready port into a small FIFO. It primes the FIFO before playback, then releases one sample per programmable update period to the SMS modulator with a one-cycle strobe. On underflow it repeats the last sample and flags the event. It sits between the `tt_um_ejfogleman_smsdac` pin-level wrapper and the modulator core.

## Interface
Parameters:
- `DW`, 8: sample width.
- `DEPTH`, 4: FIFO depth; power of two, ≥ 2.
- `DIVW`, 8: width of the rate divider.

Ports:
- `clk` input 1: single clock; all logic is on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `ena` input 1: block enable; low freezes all state.
- `run` input 1: level; high requests playback.
- `rate` input DIVW: update period is `rate`+1 cycles.
- `in_data` input DW: sample from the requester.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: FIFO can accept a word.
- `clr` input 1: clears `underflow`.
- `mod_data` output DW: registered sample to the modulator.
- `mod_strobe` output 1: one-cycle pulse; `mod_data` changed on this cycle.
- `underflow` output 1: sticky flag, set when a strobe finds the FIFO empty.
- `fill` output $clog2(DEPTH)+1: registered FIFO occupancy.
- `state` output 2: 0=IDLE, 1=PRIME, 2=RUN.

## Operation
- FIFO:
  - Circular buffer with a read pointer, a write pointer and the `fill` count.
  - Push occurs when `in_valid && in_ready` at a clock edge.
  - `in_ready` = `rst_n && ena && fill < DEPTH`. It is combinational from registered `fill`.
- Divider counter `cnt` (DIVW bits):
  - Cleared to 0 in IDLE and PRIME, and on entry to RUN.
  - Counts in RUN only.
- State machine (all transitions gated by `ena`):
  - IDLE → PRIME when `run`=1.
  - PRIME → RUN when `run`=1 and `fill` ≥ DEPTH/2. The test uses registered `fill`.
  - PRIME → IDLE when `run`=0.
  - RUN → IDLE when `run`=0. This takes effect on the next edge, and no strobe is issued on that edge.
- RUN, each enabled cycle:
  - If `cnt` ≥ `rate`:
    - `cnt` ← 0 and `mod_strobe` ← 1.
    - If `fill` > 0: pop, and `mod_data` ← head word.
    - Else: `mod_data` holds its value and `underflow` ← 1.
  - Otherwise: `cnt` ← `cnt`+1 and `mod_strobe` ← 0.
  - The `≥` compare means that lowering `rate` mid-run yields a strobe on the next cycle, never a 2^DIVW-cycle gap.
- IDLE:
  - `mod_data` ← midscale (1<<(DW-1)); `mod_strobe` ← 0.
  - FIFO contents are retained, and pushes are still accepted.
- `underflow`:
  - Clears on `clr`=1.
  - Set and `clr` in the same cycle: set wins.
- `ena`=0: all registers hold, `in_ready`=0 and `mod_strobe`=0.

## Timing
- Reset values (sampled on an edge with `rst_n`=0):
  - state=IDLE, `cnt`=0, pointers=0, `fill`=0.
  - `mod_data`=0x80 (midscale), `mod_strobe`=0, `underflow`=0.
  - `in_ready`=0 while `rst_n` is low.
- Reset mid-operation discards FIFO contents. Outputs reach the reset values after the first reset edge.
- Push latency: a word pushed at edge N is counted in `fill` after N. It is eligible to pop from edge N+1.
- Simultaneous push and pop: `fill` is unchanged and both pointers advance.
- Push into an empty FIFO on a strobe edge: the strobe sees `fill`=0, so it is an underflow with repeat. The pushed word is kept.
- Full FIFO: `in_ready`=0, so no overflow is possible.
- First strobe is asserted `rate`+1 cycles after `state` first reads RUN. After that, strobes come every `rate`+1 cycles. `rate`=0 gives a strobe every cycle.
- `mod_strobe` and the new `mod_data` are registered together, on the same edge.
- `state`, `fill` and `underflow` are registered. They change only on edges.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with `in_valid`=1.
  - Required: `in_ready`=0, `mod_data`=0x80, `mod_strobe`=0, `fill`=0, `state`=0.
- **Prime and play:** `rate`=3, push 0x10, 0x20, 0x30, 0x40, then raise `run`.
  - Required: RUN is entered once `fill` ≥ 2.
  - Strobes come every 4 cycles, with `mod_data` = 0x10, 0x20, 0x30, 0x40 in order.
- **Underflow:** continue the previous run with no pushes.
  - Required: the 5th strobe keeps `mod_data`=0x40 and `underflow`=1.
  - `clr` asserted together with the next empty strobe leaves `underflow`=1.
  - `clr` alone then gives 0.
- **Backpressure:** fill 4 words with `run`=0.
  - Required: `in_ready`=0 and a 5th `in_valid` is not accepted, so `fill` stays 4.
  - One strobe in RUN restores `in_ready`=1 on the next cycle.
- **Rate change and freeze:**
  - `rate`=200 with `cnt` at 50, change `rate` to 10. Required: a strobe on the next cycle.
  - `ena`=0 for 5 cycles. Required: `cnt`, `fill` and `mod_data` unchanged, and no strobe.
- **Stop:** drop `run` mid-RUN.
  - Required: the next edge gives `state`=0 and `mod_data`=0x80, with no strobe.
  - Remaining FIFO words are still present in `fill`.
